// File: rtl/lampfpu_log_rndr_pkg.sv
// Shared bfloat16 constants, rounder FSM state type and the round-to-nearest-even helper
// used by the log, divide and sqrt result paths.
package lampfpu_log_rndr_pkg;

    localparam int LAMP_FLOAT_E_DW   = 8;
    localparam int LAMP_FLOAT_F_DW   = 7;
    localparam int LAMP_FLOAT_E_BIAS = 127;

    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F =
        {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] QNAN_E_F =
        {{LAMP_FLOAT_E_DW{1'b1}}, 1'b1, {(LAMP_FLOAT_F_DW-1){1'b0}}};

    typedef enum logic [1:0] {
        RNDR_IDLE = 2'd0,
        RNDR_RND  = 2'd1,
        RNDR_OUT  = 2'd2
    } rndrState_t;

    typedef struct packed {
        logic [LAMP_FLOAT_E_DW:0] eExt;
        logic [LAMP_FLOAT_F_DW:0] mant;
        logic                     inexact;
    } rndRes_t;

    // mantGrs = {hidden, frac, G, R, S}; a carry out of the hidden bit renormalises
    // to 1.0 and bumps the exponent, which is kept one bit wider to expose overflow.
    function automatic rndRes_t FUNC_rndNearestEven(
        input logic [LAMP_FLOAT_E_DW:0]   eExt,
        input logic [LAMP_FLOAT_F_DW+3:0] mantGrs
    );
        rndRes_t                  res;
        logic [LAMP_FLOAT_F_DW:0] mant;
        logic [LAMP_FLOAT_F_DW+1:0] sum;
        logic                     g;
        logic                     r;
        logic                     s;
        logic                     inc;
        mant = mantGrs[LAMP_FLOAT_F_DW+3:3];
        g    = mantGrs[2];
        r    = mantGrs[1];
        s    = mantGrs[0];
        inc  = g & (r | s | mant[0]);
        sum  = {1'b0, mant} + {{(LAMP_FLOAT_F_DW+1){1'b0}}, inc};
        res.inexact = g | r | s;
        if (sum[LAMP_FLOAT_F_DW+1]) begin
            res.mant = {1'b1, {LAMP_FLOAT_F_DW{1'b0}}};
            res.eExt = eExt + 1'b1;
        end else begin
            res.mant = sum[LAMP_FLOAT_F_DW:0];
            res.eExt = eExt;
        end
        return res;
    endfunction

endpackage

// File: rtl/lampfpu_rnd_core.sv
// Combinational rounding datapath: overflow-bit pre-shift, RNE, then Inf/zero resolution
// with overflow taking priority over flush-to-zero.
module lampfpu_rnd_core
    import lampfpu_log_rndr_pkg::*;
#(
    parameter int E_DW    = LAMP_FLOAT_E_DW,
    parameter int F_DW    = LAMP_FLOAT_F_DW,
    parameter int EXP_MAX = 255
) (
    input  logic                   s,
    input  logic [E_DW-1:0]        e,
    input  logic [F_DW+4:0]        f,
    input  logic                   isOverflow,
    input  logic                   isUnderflow,
    input  logic                   isToRound,
    output logic [E_DW+F_DW:0]     result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    localparam logic [E_DW:0] EXP_MAX_X = (E_DW+1)'(EXP_MAX);

    logic [E_DW:0]   preE;
    logic [F_DW+3:0] preMant;
    rndRes_t         rnd;
    logic            isOvf;
    logic            isUnf;

    // A set overflow bit means the mantissa is in [2,4): renormalise while keeping sticky.
    always_comb begin
        preE    = {1'b0, e};
        preMant = f[F_DW+3:0];
        if (f[F_DW+4]) begin
            preE    = {1'b0, e} + 1'b1;
            preMant = {f[F_DW+4:2], f[1] | f[0]};
        end
    end

    assign rnd   = FUNC_rndNearestEven(preE, preMant);
    assign isOvf = isOverflow | (rnd.eExt >= EXP_MAX_X);
    assign isUnf = isUnderflow | (e == '0) | ~rnd.mant[F_DW];

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = 1'b0;
        if (!isToRound) begin
            result = {s, e, f[F_DW+2:3]};
        end else begin
            inexact = rnd.inexact;
            if (isOvf) begin
                result   = {s, INF_E_F};
                overflow = 1'b1;
            end else if (isUnf) begin
                result    = {s, {(E_DW+F_DW){1'b0}}};
                underflow = 1'b1;
            end else begin
                result = {s, rnd.eExt[E_DW-1:0], rnd.mant[F_DW-1:0]};
            end
        end
    end

endmodule

// File: rtl/lampfpu_log_rndr.sv
// Log-unit result rounder: captures the one-cycle result pulse, rounds it on the next
// cycle and holds the packed bfloat16 word under a valid/ack handshake.
module lampfpu_log_rndr
    import lampfpu_log_rndr_pkg::*;
#(
    parameter int E_DW    = LAMP_FLOAT_E_DW,
    parameter int F_DW    = LAMP_FLOAT_F_DW,
    parameter int EXP_MAX = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   s_i,
    input  logic [E_DW-1:0]        e_i,
    input  logic [F_DW+4:0]        f_i,
    input  logic                   isOverflow_i,
    input  logic                   isUnderflow_i,
    input  logic                   isToRound_i,
    input  logic                   ack_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [E_DW+F_DW:0]     result_o,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inexact_o,
    output logic                   drop_o
);

    rndrState_t          state;

    logic                capS_p0;
    logic [E_DW-1:0]     capE_p0;
    logic [F_DW+4:0]     capF_p0;
    logic                capOvf_p0;
    logic                capUnf_p0;
    logic                capToRound_p0;

    logic [E_DW+F_DW:0]  coreResult_p1;
    logic                coreOvf_p1;
    logic                coreUnf_p1;
    logic                coreInexact_p1;

    assign ready_o = (state == RNDR_IDLE);

    lampfpu_rnd_core #(
        .E_DW    (E_DW),
        .F_DW    (F_DW),
        .EXP_MAX (EXP_MAX)
    ) uRndCore (
        .s           (capS_p0),
        .e           (capE_p0),
        .f           (capF_p0),
        .isOverflow  (capOvf_p0),
        .isUnderflow (capUnf_p0),
        .isToRound   (capToRound_p0),
        .result      (coreResult_p1),
        .overflow    (coreOvf_p1),
        .underflow   (coreUnf_p1),
        .inexact     (coreInexact_p1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RNDR_IDLE;
            capS_p0       <= 1'b0;
            capE_p0       <= '0;
            capF_p0       <= '0;
            capOvf_p0     <= 1'b0;
            capUnf_p0     <= 1'b0;
            capToRound_p0 <= 1'b0;
            valid_o       <= 1'b0;
            result_o      <= '0;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            inexact_o     <= 1'b0;
            drop_o        <= 1'b0;
        end else begin
            if (valid_i && (state != RNDR_IDLE)) begin
                drop_o <= 1'b1;
            end
            case (state)
                // p0: capture the log unit's result pulse
                RNDR_IDLE: begin
                    if (valid_i) begin
                        capS_p0       <= s_i;
                        capE_p0       <= e_i;
                        capF_p0       <= f_i;
                        capOvf_p0     <= isOverflow_i;
                        capUnf_p0     <= isUnderflow_i;
                        capToRound_p0 <= isToRound_i;
                        state         <= RNDR_RND;
                    end
                end
                // p1: register the rounded word and flags
                RNDR_RND: begin
                    result_o    <= coreResult_p1;
                    overflow_o  <= coreOvf_p1;
                    underflow_o <= coreUnf_p1;
                    inexact_o   <= coreInexact_p1;
                    valid_o     <= 1'b1;
                    state       <= RNDR_OUT;
                end
                RNDR_OUT: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        state   <= RNDR_IDLE;
                    end
                end
                default: state <= RNDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lampfpu_log_rndr.sv
// Scoreboard bench for the log-unit rounder: expected words are queued at stimulus time
// and popped when valid_o rises.
module tb_lampfpu_log_rndr;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        s_i;
    logic [7:0]  e_i;
    logic [11:0] f_i;
    logic        isOverflow_i;
    logic        isUnderflow_i;
    logic        isToRound_i;
    logic        ack_i;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] result_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        inexact_o;
    logic        drop_o;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    exp_t expQ[$];
    int   chkCnt  = 0;
    int   passCnt = 0;

    always #5 clk = ~clk;

    lampfpu_log_rndr #(
        .E_DW    (8),
        .F_DW    (7),
        .EXP_MAX (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .s_i           (s_i),
        .e_i           (e_i),
        .f_i           (f_i),
        .isOverflow_i  (isOverflow_i),
        .isUnderflow_i (isUnderflow_i),
        .isToRound_i   (isToRound_i),
        .ack_i         (ack_i),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .result_o      (result_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o),
        .inexact_o     (inexact_o),
        .drop_o        (drop_o)
    );

    task automatic chkVal(input string tag, input logic [15:0] got, input logic [15:0] want);
        chkCnt++;
        if (got === want) passCnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Integer reference: mantissa treated as a 12-bit fixed-point number, 3 fraction bits
    // below the stored LSB.
    function automatic exp_t refRound(input logic s, input logic [7:0] e, input logic [11:0] f,
                                      input logic iO, input logic iU);
        exp_t r;
        int   m;
        int   ex;
        int   rem;
        int   keep;
        m  = int'(f);
        ex = int'(e);
        if (m >= 2048) begin
            m  = (m >> 1) | (m & 1);
            ex = ex + 1;
        end
        rem   = m % 8;
        keep  = m / 8;
        r.inx = (rem != 0);
        if (rem > 4 || (rem == 4 && keep % 2 == 1)) keep = keep + 1;
        if (keep == 256) begin
            keep = 128;
            ex   = ex + 1;
        end
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (ex >= 255 || iO) begin
            r.res = {s, 8'hFF, 7'h00};
            r.ovf = 1'b1;
        end else if (iU || e == 8'h00 || keep < 128) begin
            r.res = {s, 15'h0000};
            r.unf = 1'b1;
        end else begin
            r.res = {s, ex[7:0], keep[6:0]};
        end
        return r;
    endfunction

    task automatic driveOp(input logic s, input logic [7:0] e, input logic [11:0] f,
                           input logic iO, input logic iU, input logic tr);
        s_i           = s;
        e_i           = e;
        f_i           = f;
        isOverflow_i  = iO;
        isUnderflow_i = iU;
        isToRound_i   = tr;
        valid_i       = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic waitOut(input string tag);
        int lat;
        lat = 1;
        while (!valid_o && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chkVal({tag, ".lat"}, 16'(lat), 16'd2);
    endtask

    task automatic cmpOut(input string tag);
        exp_t x;
        if (expQ.size() == 0) begin
            chkVal({tag, ".qEmpty"}, 16'd0, 16'd1);
        end else begin
            x = expQ.pop_front();
            chkVal({tag, ".res"}, result_o, x.res);
            chkVal({tag, ".ovf"}, 16'(overflow_o), 16'(x.ovf));
            chkVal({tag, ".unf"}, 16'(underflow_o), 16'(x.unf));
            chkVal({tag, ".inx"}, 16'(inexact_o), 16'(x.inx));
        end
    endtask

    task automatic ackOut(input string tag);
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
        chkVal({tag, ".ackVld"}, 16'(valid_o), 16'd0);
        chkVal({tag, ".ackRdy"}, 16'(ready_o), 16'd1);
    endtask

    task automatic runOp(input string tag, input logic s, input logic [7:0] e, input logic [11:0] f,
                         input logic iO, input logic iU, input logic tr,
                         input logic [15:0] res, input logic ovf, input logic unf, input logic inx);
        exp_t x;
        x.res = res;
        x.ovf = ovf;
        x.unf = unf;
        x.inx = inx;
        expQ.push_back(x);
        chkVal({tag, ".rdy"}, 16'(ready_o), 16'd1);
        driveOp(s, e, f, iO, iU, tr);
        waitOut(tag);
        chkVal({tag, ".busy"}, 16'(ready_o), 16'd0);
        cmpOut(tag);
        ackOut(tag);
    endtask

    initial begin
        exp_t        r;
        logic        rs;
        logic [7:0]  re;
        logic [11:0] rf;

        rst           = 1'b1;
        valid_i       = 1'b0;
        s_i           = 1'b0;
        e_i           = 8'h00;
        f_i           = 12'h000;
        isOverflow_i  = 1'b0;
        isUnderflow_i = 1'b0;
        isToRound_i   = 1'b0;
        ack_i         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkVal("rst.rdy", 16'(ready_o), 16'd1);
        chkVal("rst.vld", 16'(valid_o), 16'd0);
        chkVal("rst.res", result_o, 16'h0000);
        chkVal("rst.drop", 16'(drop_o), 16'd0);
        chkVal("rst.flags", 16'({overflow_o, underflow_o, inexact_o}), 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runOp("basic",   1'b0, 8'h7E, 12'b0_1_0110001_011, 1'b0, 1'b0, 1'b1, 16'h3F31, 1'b0, 1'b0, 1'b1);
        runOp("tieOdd",  1'b0, 8'h7F, 12'b0_1_0000001_100, 1'b0, 1'b0, 1'b1, 16'h3F82, 1'b0, 1'b0, 1'b1);
        runOp("tieEven", 1'b0, 8'h7F, 12'b0_1_0000000_100, 1'b0, 1'b0, 1'b1, 16'h3F80, 1'b0, 1'b0, 1'b1);
        runOp("carry",   1'b0, 8'h7F, 12'b0_1_1111111_110, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b1);
        runOp("carryOv", 1'b0, 8'hFE, 12'b0_1_1111111_110, 1'b0, 1'b0, 1'b1, 16'h7F80, 1'b1, 1'b0, 1'b1);
        runOp("preShft", 1'b0, 8'h7F, 12'b1_0_0000001_000, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b1);
        runOp("unfFlag", 1'b1, 8'h7F, 12'b0_1_0000000_000, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        runOp("ovfFlag", 1'b0, 8'h80, 12'b0_1_0000000_010, 1'b1, 1'b0, 1'b1, 16'h7F80, 1'b1, 1'b0, 1'b1);
        runOp("ovfPrio", 1'b1, 8'h80, 12'b0_1_0000000_000, 1'b1, 1'b1, 1'b1, 16'hFF80, 1'b1, 1'b0, 1'b0);
        runOp("eZero",   1'b0, 8'h00, 12'b0_1_1000000_000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        runOp("noHid",   1'b0, 8'h40, 12'b0_0_1010101_000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        runOp("special", 1'b1, 8'hFF, 12'b0_0_1000000_101, 1'b0, 1'b0, 1'b0, 16'hFFC0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            re = 8'($urandom_range(1, 254));
            rf = 12'($urandom_range(0, 4095));
            r  = refRound(rs, re, rf, 1'b0, 1'b0);
            runOp("rand", rs, re, rf, 1'b0, 1'b0, 1'b1, r.res, r.ovf, r.unf, r.inx);
        end

        chkVal("noDrop", 16'(drop_o), 16'd0);

        // Hold without ack; a second strobe during OUT must be dropped.
        expQ.push_back(exp_t'({16'h3F31, 1'b0, 1'b0, 1'b1}));
        driveOp(1'b0, 8'h7E, 12'b0_1_0110001_011, 1'b0, 1'b0, 1'b1);
        waitOut("hold");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                valid_i = 1'b1;
                e_i     = 8'h01;
                f_i     = 12'hFFF;
            end
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            chkVal("hold.vld", 16'(valid_o), 16'd1);
            chkVal("hold.res", result_o, 16'h3F31);
        end
        chkVal("hold.drop", 16'(drop_o), 16'd1);
        cmpOut("hold");
        ackOut("hold");
        chkVal("dropSticky", 16'(drop_o), 16'd1);

        // Asynchronous reset while in RND.
        driveOp(1'b0, 8'h7F, 12'b0_1_0000001_100, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chkVal("midRst.rdy", 16'(ready_o), 16'd1);
        chkVal("midRst.vld", 16'(valid_o), 16'd0);
        chkVal("midRst.res", result_o, 16'h0000);
        chkVal("midRst.drop", 16'(drop_o), 16'd0);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkVal("postRst.vld", 16'(valid_o), 16'd0);
        chkVal("postRst.rdy", 16'(ready_o), 16'd1);

        runOp("recover", 1'b0, 8'h7F, 12'b0_1_0000001_100, 1'b0, 1'b0, 1'b1, 16'h3F82, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/lampfpu_log_rndr.md
Name: lampfpu_log_rndr

Overview:
Post-normalisation and rounding stage directly downstream of the bfloat16 log unit. Captures the log unit's one-cycle result pulse (sign, exponent, 12-bit extended mantissa, flags) and rounds the mantissa round-to-nearest-even. Handles mantissa carry, exponent overflow/underflow and NaN/Inf pass-through. Packs a 16-bit bfloat16 word and holds it under a valid/ack handshake toward FPU writeback.

Parameters:
E_DW, 8, exponent width (LAMP_FLOAT_E_DW)
F_DW, 7, stored fraction width (LAMP_FLOAT_F_DW)
EXP_MAX, 255, all-ones exponent (Inf/NaN encoding)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_i  in  1  one-cycle result strobe from log unit
s_i  in  1  result sign
e_i  in  E_DW  biased exponent
f_i  in  F_DW+5  [11]=overflow bit, [10]=hidden, [9:3]=fraction, [2]=G, [1]=R, [0]=S
isOverflow_i  in  1  log-unit overflow
isUnderflow_i  in  1  log-unit underflow
isToRound_i  in  1  1=normal result; 0=special (NaN/Inf), pass through
ack_i  in  1  consumer accepts result
ready_o  out  1  block idle, may capture valid_i
valid_o  out  1  result_o valid, held until ack_i
result_o  out  1+E_DW+F_DW  packed {s,e,frac}
overflow_o  out  1  result became Inf by overflow
underflow_o  out  1  result flushed to zero
inexact_o  out  1  G|R|S nonzero before rounding
drop_o  out  1  sticky: valid_i arrived while not ready

Behaviour:
- Reset (async, any state): state IDLE, all outputs and internal registers 0 (ready_o is combinational and reads 1 in IDLE).
- FSM IDLE/RND/OUT; ready_o = (state==IDLE).
- IDLE: valid_i=1 -> capture all inputs, go RND. Capture uses the same edge as valid_i.
- RND: compute result into output registers; go OUT. valid_o rises on that edge.
- OUT: valid_o=1 and result/flags stable. ack_i=1 -> next edge valid_o=0, go IDLE. Otherwise hold indefinitely.
- Latency: valid_i at edge N, valid_o high after edge N+2. ack_i in the first OUT cycle gives ready_o high after N+3; minimum initiation interval 3 cycles.
- valid_i while ready_o=0: input ignored, drop_o set; cleared only by reset.
- Rounding when isToRound_i=1:
  - Pre-shift: if f[11]=1, shift right 1 and OR the shifted-out bit into S; e+1.
  - RNE: increment 8-bit {hidden,frac} when G & (R|S|frac[0]). inexact_o = G|R|S after pre-shift.
  - Carry out of hidden bit: mantissa=1.0000000, e+1.
  - Exponent arithmetic in E_DW+1 bits. If e>=EXP_MAX, or isOverflow_i: result {s,FF,0000000}, overflow_o=1.
  - If isUnderflow_i, or captured e==0, or hidden bit 0 after rounding: result {s,00,0000000}, underflow_o=1 (flush-to-zero, no denormals).
  - Overflow has priority over underflow.
- isToRound_i=0: result {s_i,e_i,f_i[9:3]} unmodified; all flags 0.

Decomposition:
- lampFPU_pkg already provides LAMP_FLOAT_E_DW, LAMP_FLOAT_F_DW, LAMP_FLOAT_E_BIAS, INF_E_F, QNAN_E_F. Add FUNC_rndNearestEven (13-bit {e,mantissa} in, rounded {e_ext,mant,inexact} out) so the divide/sqrt paths reuse it.
- Add typedef for the FSM enum in the package.
- One combinational sub-module, lampfpu_rnd_core: pre-shift, RNE, overflow/underflow resolution. The top holds only the FSM and registers.

Test Plan:
- s=0,e=0x7E,f=0_1_0110001_011,isToRound=1 -> result 0x3F31, inexact=1, valid_o 2 cycles after valid_i.
- e=0x7F, f=0_1_0000001_100 -> 0x3F82 (tie, odd LSB rounds up); f=0_1_0000000_100 -> 0x3F80 (tie to even), inexact=1.
- e=0x7F, f=0_1_1111111_110 -> 0x4000 (carry). Same f with e=0xFE -> 0x7F80, overflow_o=1.
- f=1_0_0000001_000, e=0x7F -> pre-shift, tie to even -> 0x4000, inexact=1. isUnderflow_i=1,s=1 -> 0x8000, underflow_o=1.
- isToRound=0, s=1, e=0xFF, f[9:3]=1000000 -> 0xFFC0, flags 0.
- Hold ack_i=0 for 5 cycles: valid_o/result stable, second valid_i ignored, drop_o=1. Assert rst mid-RND -> valid_o=0, ready_o=1 immediately.
